collision_engine: RTL and testbench

- Clocked, multi-obstacle successor to the tank-game combinational collision logic.
- On each frame_start it snapshots tank and bullet geometry and scans N_OBS parametrised rectangular obstacles, one per cycle.
- It resolves tank-vs-tank and bullet-vs-tank hits with shield gating, then publishes registered collision codes plus per-tank saturating hit counters with a cooldown.
- Sits between the tank/bullet motion controllers and the colour mapper.

---
 rtl/collision_engine.sv | 207 ++++++++++++++++++++
 tb/tb_collision_engine.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_engine.sv
// collision_engine: per-frame snapshot, one-obstacle-per-cycle scan, then tank/bullet pair resolution; done at frame_start+N_OBS+3.
// frame_start while not IDLE is dropped and sets sticky overrun; define OBSTACLE_DRAW_EN for the registered obstacle_on pixel test.
module collision_engine #(
  parameter int                  N_OBS        = 4,
  parameter logic [N_OBS*10-1:0] OBS_X        = {10'd310, 10'd100, 10'd500, 10'd200},
  parameter logic [N_OBS*10-1:0] OBS_Y        = {10'd100, 10'd300, 10'd240, 10'd400},
  parameter logic [N_OBS*10-1:0] OBS_SX       = {N_OBS{10'd30}},
  parameter logic [N_OBS*10-1:0] OBS_SY       = {N_OBS{10'd30}},
  parameter int                  HIT_COOLDOWN = 3,
  parameter int                  CNT_W        = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_start,
  input  logic [9:0]       BallX,    BallY,    BallSx,    BallSy,
  input  logic [9:0]       Ball2X,   Ball2Y,   Ball2Sx,   Ball2Sy,
  input  logic [9:0]       BulletX,  BulletY,  BulletSx,  BulletSy,
  input  logic [9:0]       Bullet2X, Bullet2Y, Bullet2Sx, Bullet2Sy,
  input  logic             field1On,
  input  logic             field2On,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  output logic             obstacle_on,
  output logic [2:0]       bounce_on,
  output logic [2:0]       bounce2_on,
  output logic [2:0]       disappear,
  output logic [2:0]       disappear2,
  output logic [2:0]       tank_bullet,
  output logic [2:0]       tank_bullet2,
  output logic [CNT_W-1:0] hits1,
  output logic [CNT_W-1:0] hits2,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int IW  = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam int CDW = (HIT_COOLDOWN > 0) ? $clog2(HIT_COOLDOWN + 1) : 1;
  localparam logic [2:0] NONE = 3'b100;
  localparam logic [2:0] HIT  = 3'b000;

  typedef enum logic [2:0] {IDLE, SNAP, SCAN, PAIR, DONE} state_t;

  // Geometry is carried packed as {x, y, sx, sy}; far edges are formed at 11 bits.
  function automatic logic ovl(input logic [39:0] a, input logic [39:0] b);
    logic [10:0] ax, ay, ax2, ay2, bx, by, bx2, by2;
    ax  = {1'b0, a[39:30]};  ay  = {1'b0, a[29:20]};
    ax2 = ax + {1'b0, a[19:10]};  ay2 = ay + {1'b0, a[9:0]};
    bx  = {1'b0, b[39:30]};  by  = {1'b0, b[29:20]};
    bx2 = bx + {1'b0, b[19:10]};  by2 = by + {1'b0, b[9:0]};
    return (ax <= bx2) && (bx <= ax2) && (ay <= by2) && (by <= ay2);
  endfunction

  function automatic logic [2:0] edge_code(input logic [39:0] a, input logic [39:0] b);
    logic [10:0] ax, ay, ax2, ay2, bx, by, bx2, by2;
    logic        xo, yo;
    ax  = {1'b0, a[39:30]};  ay  = {1'b0, a[29:20]};
    ax2 = ax + {1'b0, a[19:10]};  ay2 = ay + {1'b0, a[9:0]};
    bx  = {1'b0, b[39:30]};  by  = {1'b0, b[29:20]};
    bx2 = bx + {1'b0, b[19:10]};  by2 = by + {1'b0, b[9:0]};
    xo  = (ax <= bx2) && (bx <= ax2);
    yo  = (ay <= by2) && (by <= ay2);
    if (ax2 == bx && yo)      return 3'b000;
    else if (ax == bx2 && yo) return 3'b001;
    else if (ay2 == by && xo) return 3'b010;
    else if (ay == by2 && xo) return 3'b011;
    else                      return NONE;
  endfunction

  function automatic logic [39:0] obs_geo(input logic [IW-1:0] i);
    return {OBS_X[int'(i)*10 +: 10], OBS_Y[int'(i)*10 +: 10],
            OBS_SX[int'(i)*10 +: 10], OBS_SY[int'(i)*10 +: 10]};
  endfunction

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [39:0]       t1_q, t1_d, t2_q, t2_d, b1_q, b1_d, b2_q, b2_d;
  logic              sh1_q, sh1_d, sh2_q, sh2_d;
  logic [2:0]        sb1_q, sb1_d, sb2_q, sb2_d, sd1_q, sd1_d, sd2_q, sd2_d;
  logic [2:0]        stb1_q, stb1_d, stb2_q, stb2_d;
  logic [2:0]        ob1_q, ob1_d, ob2_q, ob2_d, od1_q, od1_d, od2_q, od2_d;
  logic [2:0]        otb1_q, otb1_d, otb2_q, otb2_d;
  logic [CNT_W-1:0]  hits1_q, hits1_d, hits2_q, hits2_d;
  logic [CDW-1:0]    cd1_q, cd1_d, cd2_q, cd2_d;
  logic              done_q, done_d, ovr_q, ovr_d;
  logic [39:0]       obs_cur;

  assign obs_cur = obs_geo(idx_q);

  always_comb begin
    state_d = state_q;  idx_d = idx_q;
    t1_d = t1_q;  t2_d = t2_q;  b1_d = b1_q;  b2_d = b2_q;
    sh1_d = sh1_q;  sh2_d = sh2_q;
    sb1_d = sb1_q;  sb2_d = sb2_q;  sd1_d = sd1_q;  sd2_d = sd2_q;
    stb1_d = stb1_q;  stb2_d = stb2_q;
    ob1_d = ob1_q;  ob2_d = ob2_q;  od1_d = od1_q;  od2_d = od2_q;
    otb1_d = otb1_q;  otb2_d = otb2_q;
    hits1_d = hits1_q;  hits2_d = hits2_q;  cd1_d = cd1_q;  cd2_d = cd2_q;
    done_d = 1'b0;
    ovr_d  = ovr_q | (frame_start && state_q != IDLE);
    case (state_q)
      IDLE: if (frame_start) state_d = SNAP;
      SNAP: begin
        t1_d = {BallX, BallY, BallSx, BallSy};
        t2_d = {Ball2X, Ball2Y, Ball2Sx, Ball2Sy};
        b1_d = {BulletX, BulletY, BulletSx, BulletSy};
        b2_d = {Bullet2X, Bullet2Y, Bullet2Sx, Bullet2Sy};
        sh1_d = field1On;  sh2_d = field2On;
        sb1_d = NONE;  sb2_d = NONE;  sd1_d = NONE;  sd2_d = NONE;
        stb1_d = NONE;  stb2_d = NONE;
        idx_d = '0;
        state_d = SCAN;
      end
      SCAN: begin
        // Scratch codes only move off NONE once, so the earliest match sticks.
        if (sb1_q == NONE) sb1_d = edge_code(t1_q, obs_cur);
        if (sb2_q == NONE) sb2_d = edge_code(t2_q, obs_cur);
        if (sd1_q == NONE && ovl(b1_q, obs_cur)) sd1_d = HIT;
        if (sd2_q == NONE && ovl(b2_q, obs_cur)) sd2_d = HIT;
        if (idx_q == IW'(N_OBS - 1)) state_d = PAIR;
        else                         idx_d = idx_q + IW'(1);
      end
      PAIR: begin
        if (sb1_q == NONE) sb1_d = edge_code(t1_q, t2_q);
        if (sb2_q == NONE) sb2_d = edge_code(t2_q, t1_q);
        stb1_d = (ovl(b1_q, t2_q) && !sh2_q) ? HIT : NONE;
        stb2_d = (ovl(b2_q, t1_q) && !sh1_q) ? HIT : NONE;
        state_d = DONE;
      end
      DONE: begin
        ob1_d = sb1_q;  ob2_d = sb2_q;  od1_d = sd1_q;  od2_d = sd2_q;
        otb1_d = stb1_q;  otb2_d = stb2_q;
        done_d = 1'b1;
        // Tank 1 is the victim of bullet 2, tank 2 of bullet 1.
        if (stb2_q == HIT && cd1_q == '0) begin
          if (hits1_q != '1) hits1_d = hits1_q + CNT_W'(1);
          cd1_d = CDW'(HIT_COOLDOWN);
        end else if (cd1_q != '0) cd1_d = cd1_q - CDW'(1);
        if (stb1_q == HIT && cd2_q == '0) begin
          if (hits2_q != '1) hits2_d = hits2_q + CNT_W'(1);
          cd2_d = CDW'(HIT_COOLDOWN);
        end else if (cd2_q != '0) cd2_d = cd2_q - CDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;  idx_q <= '0;
      t1_q <= '0;  t2_q <= '0;  b1_q <= '0;  b2_q <= '0;
      sh1_q <= 1'b0;  sh2_q <= 1'b0;
      sb1_q <= NONE;  sb2_q <= NONE;  sd1_q <= NONE;  sd2_q <= NONE;
      stb1_q <= NONE;  stb2_q <= NONE;
      ob1_q <= NONE;  ob2_q <= NONE;  od1_q <= NONE;  od2_q <= NONE;
      otb1_q <= NONE;  otb2_q <= NONE;
      hits1_q <= '0;  hits2_q <= '0;  cd1_q <= '0;  cd2_q <= '0;
      done_q <= 1'b0;  ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;  idx_q <= idx_d;
      t1_q <= t1_d;  t2_q <= t2_d;  b1_q <= b1_d;  b2_q <= b2_d;
      sh1_q <= sh1_d;  sh2_q <= sh2_d;
      sb1_q <= sb1_d;  sb2_q <= sb2_d;  sd1_q <= sd1_d;  sd2_q <= sd2_d;
      stb1_q <= stb1_d;  stb2_q <= stb2_d;
      ob1_q <= ob1_d;  ob2_q <= ob2_d;  od1_q <= od1_d;  od2_q <= od2_d;
      otb1_q <= otb1_d;  otb2_q <= otb2_d;
      hits1_q <= hits1_d;  hits2_q <= hits2_d;  cd1_q <= cd1_d;  cd2_q <= cd2_d;
      done_q <= done_d;  ovr_q <= ovr_d;
    end
  end

  assign bounce_on    = ob1_q;
  assign bounce2_on   = ob2_q;
  assign disappear    = od1_q;
  assign disappear2   = od2_q;
  assign tank_bullet  = otb1_q;
  assign tank_bullet2 = otb2_q;
  assign hits1        = hits1_q;
  assign hits2        = hits2_q;
  assign done         = done_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q == SNAP) || (state_q == SCAN) || (state_q == PAIR);

`ifdef OBSTACLE_DRAW_EN
  logic obs_on_q, obs_on_d;

  always_comb begin
    obs_on_d = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      if (ovl({DrawX, DrawY, 20'd0}, obs_geo(IW'(i)))) obs_on_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) obs_on_q <= 1'b0;
    else        obs_on_q <= obs_on_d;
  end

  assign obstacle_on = obs_on_q;
`else
  logic draw_unused;
  assign draw_unused = ^{DrawX, DrawY};
  assign obstacle_on = 1'b0;
`endif

endmodule

// File: tb/tb_collision_engine.sv
// Directed bench for collision_engine: main instance with defaults, plus a CNT_W=2 / no-cooldown instance for saturation.
module tb_collision_engine;
  logic Clk = 1'b0;
  logic Reset, frame_start, fs_b;
  logic [9:0] BallX, BallY, BallSx, BallSy, Ball2X, Ball2Y, Ball2Sx, Ball2Sy;
  logic [9:0] BulletX, BulletY, BulletSx, BulletSy, Bullet2X, Bullet2Y, Bullet2Sx, Bullet2Sy;
  logic field1On, field2On;
  logic [9:0] DrawX, DrawY;
  logic obstacle_on, busy, done, overrun;
  logic [2:0] bounce_on, bounce2_on, disappear, disappear2, tank_bullet, tank_bullet2;
  logic [3:0] hits1, hits2;
  logic obstacle_on_b, busy_b, done_b, overrun_b;
  logic [2:0] bounce_on_b, bounce2_on_b, disappear_b, disappear2_b, tank_bullet_b, tank_bullet2_b;
  logic [1:0] hits1_b, hits2_b;
  logic [17:0] codes;
  int checks = 0;
  int passes = 0;

  always #5 Clk = ~Clk;
  assign codes = {bounce_on, bounce2_on, disappear, disappear2, tank_bullet, tank_bullet2};

  collision_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .BallX(BallX), .BallY(BallY), .BallSx(BallSx), .BallSy(BallSy),
    .Ball2X(Ball2X), .Ball2Y(Ball2Y), .Ball2Sx(Ball2Sx), .Ball2Sy(Ball2Sy),
    .BulletX(BulletX), .BulletY(BulletY), .BulletSx(BulletSx), .BulletSy(BulletSy),
    .Bullet2X(Bullet2X), .Bullet2Y(Bullet2Y), .Bullet2Sx(Bullet2Sx), .Bullet2Sy(Bullet2Sy),
    .field1On(field1On), .field2On(field2On), .DrawX(DrawX), .DrawY(DrawY),
    .obstacle_on(obstacle_on), .bounce_on(bounce_on), .bounce2_on(bounce2_on),
    .disappear(disappear), .disappear2(disappear2),
    .tank_bullet(tank_bullet), .tank_bullet2(tank_bullet2),
    .hits1(hits1), .hits2(hits2), .busy(busy), .done(done), .overrun(overrun)
  );

  collision_engine #(.CNT_W(2), .HIT_COOLDOWN(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_start(fs_b),
    .BallX(BallX), .BallY(BallY), .BallSx(BallSx), .BallSy(BallSy),
    .Ball2X(Ball2X), .Ball2Y(Ball2Y), .Ball2Sx(Ball2Sx), .Ball2Sy(Ball2Sy),
    .BulletX(BulletX), .BulletY(BulletY), .BulletSx(BulletSx), .BulletSy(BulletSy),
    .Bullet2X(Bullet2X), .Bullet2Y(Bullet2Y), .Bullet2Sx(Bullet2Sx), .Bullet2Sy(Bullet2Sy),
    .field1On(field1On), .field2On(field2On), .DrawX(DrawX), .DrawY(DrawY),
    .obstacle_on(obstacle_on_b), .bounce_on(bounce_on_b), .bounce2_on(bounce2_on_b),
    .disappear(disappear_b), .disappear2(disappear2_b),
    .tank_bullet(tank_bullet_b), .tank_bullet2(tank_bullet2_b),
    .hits1(hits1_b), .hits2(hits2_b), .busy(busy_b), .done(done_b), .overrun(overrun_b)
  );

  task automatic set_tank1(input int x, input int y);
    BallX = 10'(x); BallY = 10'(y); BallSx = 10'd30; BallSy = 10'd30;
  endtask

  task automatic set_tank2(input int x, input int y);
    Ball2X = 10'(x); Ball2Y = 10'(y); Ball2Sx = 10'd30; Ball2Sy = 10'd30;
  endtask

  task automatic set_defaults;
    BallX = 10'd0; BallY = 10'd0; BallSx = 10'd10; BallSy = 10'd10;
    Ball2X = 10'd900; Ball2Y = 10'd900; Ball2Sx = 10'd10; Ball2Sy = 10'd10;
    BulletX = 10'd50; BulletY = 10'd600; BulletSx = 10'd2; BulletSy = 10'd2;
    Bullet2X = 10'd800; Bullet2Y = 10'd50; Bullet2Sx = 10'd2; Bullet2Sy = 10'd2;
    field1On = 1'b0; field2On = 1'b0;
  endtask

  task automatic start_frame(input bit sel);
    @(negedge Clk);
    if (sel) fs_b = 1'b1; else frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0; fs_b = 1'b0;
  endtask

  // Edge count after the accepting edge; 0 means done never arrived.
  task automatic wait_done(input bit sel, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk); #1;
      if ((sel ? done_b : done) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_frame(input bit sel, output int lat);
    start_frame(sel);
    wait_done(sel, lat);
  endtask

  task automatic test_reset;
    Reset = 1'b0; frame_start = 1'b0; fs_b = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0;
    set_defaults();
    #12;
    checks++; if (codes !== {6{3'b100}}) $display("FAIL reset_codes: got %b want %b", codes, {6{3'b100}}); else passes++;
    checks++; if (hits1 !== 4'd0) $display("FAIL reset_hits1: got %0d want 0", hits1); else passes++;
    checks++; if (hits2 !== 4'd0) $display("FAIL reset_hits2: got %0d want 0", hits2); else passes++;
    checks++; if ({busy, done, overrun, obstacle_on} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {busy, done, overrun, obstacle_on}); else passes++;
    checks++; if (hits1_b !== 2'd0) $display("FAIL reset_hits1_b: got %0d want 0", hits1_b); else passes++;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_left_face;
    int lat;
    logic [17:0] exp_c;
    exp_c = {3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    set_tank1(280, 110);
    start_frame(1'b0);
    checks++; if (busy !== 1'b1) $display("FAIL left_busy: got %b want 1", busy); else passes++;
    wait_done(1'b0, lat);
    checks++; if (lat !== 7) $display("FAIL left_latency: got %0d want 7", lat); else passes++;
    checks++; if (codes !== exp_c) $display("FAIL left_codes: got %b want %b", codes, exp_c); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL left_busy_done: got %b want 0", busy); else passes++;
    @(posedge Clk); #1;
    checks++; if ({done, codes} !== {1'b0, exp_c}) $display("FAIL left_hold: got %b want %b", {done, codes}, {1'b0, exp_c}); else passes++;
    set_defaults();
  endtask

  task automatic test_priority;
    int lat;
    logic [17:0] exp_c;
    set_tank1(205, 370); set_tank2(235, 370);
    run_frame(1'b0, lat);
    exp_c = {3'b010, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100};
    checks++; if (codes !== exp_c) $display("FAIL prio_obstacle: got %b want %b", codes, exp_c); else passes++;
    set_tank1(205, 200); set_tank2(235, 200);
    run_frame(1'b0, lat);
    exp_c = {3'b000, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100};
    checks++; if (codes !== exp_c) $display("FAIL prio_tank: got %b want %b", codes, exp_c); else passes++;
    set_defaults();
  endtask

  task automatic test_bullet_obstacle;
    int lat;
    logic [17:0] exp_c;
    Bullet2X = 10'd205; Bullet2Y = 10'd405;
    run_frame(1'b0, lat);
    exp_c = {3'b100, 3'b100, 3'b100, 3'b000, 3'b100, 3'b100};
    checks++; if (codes !== exp_c) $display("FAIL bullet_obstacle: got %b want %b", codes, exp_c); else passes++;
    set_defaults();
  endtask

  task automatic test_shield;
    int lat;
    logic [17:0] exp_c;
    set_tank2(600, 20);
    BulletX = 10'd605; BulletY = 10'd25; BulletSx = 10'd4; BulletSy = 10'd4;
    field2On = 1'b1;
    run_frame(1'b0, lat);
    checks++; if (codes !== {6{3'b100}}) $display("FAIL shield_on_codes: got %b want %b", codes, {6{3'b100}}); else passes++;
    checks++; if (hits2 !== 4'd0) $display("FAIL shield_on_hits2: got %0d want 0", hits2); else passes++;
    field2On = 1'b0;
    run_frame(1'b0, lat);
    exp_c = {3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b100};
    checks++; if (codes !== exp_c) $display("FAIL shield_off_codes: got %b want %b", codes, exp_c); else passes++;
    checks++; if (hits2 !== 4'd1) $display("FAIL shield_off_hits2: got %0d want 1", hits2); else passes++;
    set_defaults();
  endtask

  task automatic test_cooldown;
    int lat;
    int exp_h[5] = '{1, 1, 1, 1, 2};
    Bullet2X = 10'd3; Bullet2Y = 10'd3;
    for (int f = 0; f < 5; f++) begin
      run_frame(1'b0, lat);
      checks++; if (hits1 !== 4'(exp_h[f])) $display("FAIL cooldown_hits1_f%0d: got %0d want %0d", f, hits1, exp_h[f]); else passes++;
      checks++; if (tank_bullet2 !== 3'b000) $display("FAIL cooldown_code_f%0d: got %b want 000", f, tank_bullet2); else passes++;
    end
    checks++; if (hits2 !== 4'd1) $display("FAIL cooldown_hits2: got %0d want 1", hits2); else passes++;
  endtask

  task automatic test_both;
    int lat;
    for (int f = 0; f < 3; f++) run_frame(1'b0, lat);
    checks++; if (hits1 !== 4'd2) $display("FAIL both_pre_hits1: got %0d want 2", hits1); else passes++;
    BulletX = 10'd905; BulletY = 10'd905;
    run_frame(1'b0, lat);
    checks++; if ({tank_bullet, tank_bullet2} !== 6'b000000)
      $display("FAIL both_codes: got %b want 000000", {tank_bullet, tank_bullet2}); else passes++;
    checks++; if (hits1 !== 4'd3) $display("FAIL both_hits1: got %0d want 3", hits1); else passes++;
    checks++; if (hits2 !== 4'd2) $display("FAIL both_hits2: got %0d want 2", hits2); else passes++;
    set_defaults();
  endtask

  task automatic test_saturation;
    int lat;
    int exp_h[5] = '{1, 2, 3, 3, 3};
    Bullet2X = 10'd3; Bullet2Y = 10'd3;
    for (int f = 0; f < 5; f++) begin
      run_frame(1'b1, lat);
      checks++; if (hits1_b !== 2'(exp_h[f])) $display("FAIL sat_hits1_f%0d: got %0d want %0d", f, hits1_b, exp_h[f]); else passes++;
    end
    checks++; if (hits2_b !== 2'd0) $display("FAIL sat_hits2: got %0d want 0", hits2_b); else passes++;
    set_defaults();
  endtask

  task automatic test_overrun;
    int ndone = 0;
    int first = 0;
    int e = 0;
    checks++; if (overrun !== 1'b0) $display("FAIL overrun_pre: got %b want 0", overrun); else passes++;
    set_tank1(280, 110);
    start_frame(1'b0);
    @(negedge Clk);
    start_frame(1'b0);
    e = 2;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk); #1;
      e++;
      if (done === 1'b1) begin
        ndone++;
        if (first == 0) first = e;
      end
    end
    checks++; if (ndone !== 1) $display("FAIL overrun_done_count: got %0d want 1", ndone); else passes++;
    checks++; if (first !== 7) $display("FAIL overrun_done_edge: got %0d want 7", first); else passes++;
    checks++; if (overrun !== 1'b1) $display("FAIL overrun_flag: got %b want 1", overrun); else passes++;
    checks++; if (bounce_on !== 3'b000) $display("FAIL overrun_bounce: got %b want 000", bounce_on); else passes++;
  endtask

  task automatic test_reset_midscan;
    int lat;
    start_frame(1'b0);
    @(posedge Clk); @(posedge Clk); #2;
    checks++; if (busy !== 1'b1) $display("FAIL midscan_busy_pre: got %b want 1", busy); else passes++;
    Reset = 1'b0;
    #1;
    checks++; if (codes !== {6{3'b100}}) $display("FAIL midscan_codes: got %b want %b", codes, {6{3'b100}}); else passes++;
    checks++; if ({hits1, hits2} !== 8'd0) $display("FAIL midscan_hits: got %h want 00", {hits1, hits2}); else passes++;
    checks++; if ({busy, done, overrun} !== 3'b000) $display("FAIL midscan_flags: got %b want 000", {busy, done, overrun}); else passes++;
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b1;
    run_frame(1'b0, lat);
    checks++; if (lat !== 7) $display("FAIL recover_latency: got %0d want 7", lat); else passes++;
    checks++; if (bounce_on !== 3'b000) $display("FAIL recover_bounce: got %b want 000", bounce_on); else passes++;
    set_defaults();
  endtask

  task automatic test_obstacle_draw;
    logic exp_in;
`ifdef OBSTACLE_DRAW_EN
    exp_in = 1'b1;
`else
    exp_in = 1'b0;
`endif
    @(negedge Clk); DrawX = 10'd310; DrawY = 10'd100;
    @(posedge Clk); #1;
    checks++; if (obstacle_on !== exp_in) $display("FAIL draw_corner: got %b want %b", obstacle_on, exp_in); else passes++;
    @(negedge Clk); DrawX = 10'd341;
    @(posedge Clk); #1;
    checks++; if (obstacle_on !== 1'b0) $display("FAIL draw_outside: got %b want 0", obstacle_on); else passes++;
    @(negedge Clk); DrawX = 10'd340; DrawY = 10'd130;
    #1;
    checks++; if (obstacle_on !== 1'b0) $display("FAIL draw_latency: got %b want 0", obstacle_on); else passes++;
    @(posedge Clk); #1;
    checks++; if (obstacle_on !== exp_in) $display("FAIL draw_far_corner: got %b want %b", obstacle_on, exp_in); else passes++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_left_face();
    test_priority();
    test_bullet_obstacle();
    test_shield();
    test_cooldown();
    test_both();
    test_saturation();
    test_overrun();
    test_reset_midscan();
    test_obstacle_draw();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
